// File: rtl/rr_arb32_pkg.sv
// Shared constants, state encoding and helpers for the 32-way round-robin arbiter.
package rr_arb32_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    // Collapses a one-hot vector into its binary index; zero input yields 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/and32.sv
// 32-input AND-reduction cell.
module and32 (
    input  logic [31:0] a,
    output logic        y
);

    assign y = &a;

endmodule

// File: rtl/rr_arb32_pick.sv
// Combinational round-robin pick: rotate so ptr lands on bit 0, take the
// lowest set bit, rotate the result back.
module rr_pick32
    import rr_arb32_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] first;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            logic [IDX_W-1:0] dst;
            // Index arithmetic wraps naturally in IDX_W bits (mod 32).
            assign src        = IDX_W'(gi) + ptr;
            assign dst        = IDX_W'(gi) - ptr;
            assign rot[gi]    = req[src];
            assign onehot[gi] = first[dst];
        end
    endgenerate

    assign first = rot & (~rot + NUM_REQ'(1));
    assign idx   = onehot_to_idx(onehot);

endmodule

// File: rtl/rr_arb32.sv
// Round-robin arbiter sharing one functional unit among 32 requesters, with a
// registered grant held until accepted and optional busy tracking.
module rr_arb32
    import rr_arb32_pkg::*;
#(
    parameter int PIPELINED_UNIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               flush,
    input  logic               unit_ready,
    input  logic               unit_done,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy,
    output logic               no_req
);

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic               gnt_valid_reg;
    logic [NUM_REQ-1:0] gnt_onehot_reg;
    logic [IDX_W-1:0]   gnt_idx_reg;
    logic               busy_reg;

    logic               fire;
    logic [NUM_REQ-1:0] pick_req;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    and32 u_no_req (
        .a (~req),
        .y (no_req)
    );

    // While granting, the picker already looks one step ahead (masked winner,
    // pointer past it) so a pipelined unit can be re-granted on the fire edge.
    assign pick_req = (state_reg == GRANT) ? (req & ~gnt_onehot_reg) : req;
    assign pick_ptr = (state_reg == GRANT) ? (gnt_idx_reg + IDX_W'(1)) : ptr_reg;
    assign pick_any = |pick_onehot;
    assign fire     = gnt_valid_reg & unit_ready;

    rr_pick32 u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            gnt_valid_reg  <= 1'b0;
            gnt_onehot_reg <= '0;
            gnt_idx_reg    <= '0;
            busy_reg       <= 1'b0;
        end else if (flush) begin
            state_reg      <= IDLE;
            gnt_valid_reg  <= 1'b0;
            gnt_onehot_reg <= '0;
            gnt_idx_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!no_req) begin
                        state_reg      <= GRANT;
                        gnt_valid_reg  <= 1'b1;
                        gnt_onehot_reg <= pick_onehot;
                        gnt_idx_reg    <= pick_idx;
                    end
                end
                GRANT: begin
                    if (fire) begin
                        ptr_reg <= pick_ptr;
                        if (PIPELINED_UNIT != 0 && pick_any) begin
                            gnt_onehot_reg <= pick_onehot;
                            gnt_idx_reg    <= pick_idx;
                        end else begin
                            state_reg      <= (PIPELINED_UNIT != 0) ? IDLE : BUSY;
                            busy_reg       <= (PIPELINED_UNIT == 0);
                            gnt_valid_reg  <= 1'b0;
                            gnt_onehot_reg <= '0;
                            gnt_idx_reg    <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (unit_done) begin
                        busy_reg <= 1'b0;
                        if (!no_req) begin
                            state_reg      <= GRANT;
                            gnt_valid_reg  <= 1'b1;
                            gnt_onehot_reg <= pick_onehot;
                            gnt_idx_reg    <= pick_idx;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    gnt_valid_reg  <= 1'b0;
                    gnt_onehot_reg <= '0;
                    gnt_idx_reg    <= '0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_reg;
    assign gnt_onehot = gnt_onehot_reg;
    assign gnt_idx    = gnt_idx_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_rr_arb32.sv
// Scoreboard bench for rr_arb32: a busy-tracking instance and a pipelined one.
module tb_rr_arb32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req0, req1;
    logic        flush0, flush1, ready0, ready1, done0, done1;
    logic        g0v, g1v, busy0, busy1, noreq0, noreq1;
    logic [31:0] g0oh, g1oh;
    logic [4:0]  g0idx, g1idx;

    int errors = 0;
    int checks = 0;
    int q0[$];
    int q1[$];
    int mptr0 = 0;
    int last0 = 0;

    always #5 clk = ~clk;

    rr_arb32 #(.PIPELINED_UNIT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .flush(flush0),
        .unit_ready(ready0), .unit_done(done0),
        .gnt_valid(g0v), .gnt_onehot(g0oh), .gnt_idx(g0idx),
        .busy(busy0), .no_req(noreq0)
    );

    rr_arb32 #(.PIPELINED_UNIT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .flush(flush1),
        .unit_ready(ready1), .unit_done(done1),
        .gnt_valid(g1v), .gnt_onehot(g1oh), .gnt_idx(g1idx),
        .busy(busy1), .no_req(noreq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Reference: linear scan from p upward, wrapping at 32.
    function automatic int ref_pick(input logic [31:0] r, input int p);
        for (int i = 0; i < 32; i++) begin
            if (r[(p + i) % 32]) return (p + i) % 32;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0();
        q0.push_back(ref_pick(req0, mptr0));
    endtask

    task automatic expect_grant0(input string tag);
        int          n;
        int          e;
        logic [31:0] oh;
        n = 0;
        while (1) begin
            step();
            n++;
            if (g0v || n >= 4) break;
        end
        check({tag, "_lat"}, n, 1);
        e = (q0.size() > 0) ? q0.pop_front() : -1;
        oh = (e >= 0) ? (32'd1 << e) : 32'd0;
        check({tag, "_idx"}, 32'(g0idx), e);
        check({tag, "_oh"}, g0oh, oh);
        last0 = e;
    endtask

    task automatic fire0(input string tag);
        ready0 = 1'b1;
        step();
        ready0 = 1'b0;
        check({tag, "_busy"}, 32'(busy0), 1);
        check({tag, "_vld"}, 32'(g0v), 0);
        mptr0 = (last0 + 1) % 32;
    endtask

    initial begin
        int          seen[32];
        int          n;
        int          k;
        int          e;
        int          p;
        int          prev;
        logic [31:0] m;

        rst = 1'b1;
        req0 = '0; req1 = '0;
        flush0 = 0; flush1 = 0; ready0 = 0; ready1 = 0; done0 = 0; done1 = 0;
        step();
        step();
        check("rst_vld", 32'(g0v), 0);
        check("rst_oh", g0oh, 0);
        check("rst_idx", 32'(g0idx), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_noreq", 32'(noreq0), 1);
        rst = 1'b0;

        // Single requester, full handshake and completion.
        req0 = 32'h0000_0001;
        #1 check("noreq_low", 32'(noreq0), 0);
        push0();
        expect_grant0("g0");
        fire0("f0");
        req0 = '0;
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        check("done_idle_busy", 32'(busy0), 0);
        check("done_idle_vld", 32'(g0v), 0);

        // Pointer wrap at 31 and direct BUSY->GRANT transitions.
        req0 = 32'h4000_0000;
        push0();
        expect_grant0("g30");
        fire0("f30");
        req0 = 32'h8000_0001;
        push0();
        done0 = 1'b1;
        expect_grant0("g31");
        done0 = 1'b0;
        fire0("f31");
        req0 = 32'h0000_0001;
        push0();
        done0 = 1'b1;
        expect_grant0("gwrap0");
        done0 = 1'b0;
        fire0("fwrap0");
        req0 = 32'h8000_0002;
        push0();
        done0 = 1'b1;
        expect_grant0("gptr1");
        done0 = 1'b0;

        // Grant stays stable while unit stalls and other requests toggle.
        for (int i = 0; i < 5; i++) begin
            req0 = $urandom() | 32'h0000_0002;
            step();
            check("hold_idx", 32'(g0idx), 1);
            check("hold_oh", g0oh, 32'h0000_0002);
        end
        fire0("fhold");
        req0 = '0;
        done0 = 1'b1;
        step();
        done0 = 1'b0;

        // Flush colliding with fire: fire discarded, pointer kept.
        req0 = 32'h0000_0220;
        push0();
        expect_grant0("gf5");
        ready0 = 1'b1;
        flush0 = 1'b1;
        step();
        ready0 = 1'b0;
        flush0 = 1'b0;
        check("flfire_vld", 32'(g0v), 0);
        check("flfire_busy", 32'(busy0), 0);
        push0();
        expect_grant0("gretry5");
        fire0("fretry5");

        // Flush in BUSY, then a stale done must not move anything.
        req0 = '0;
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        check("flbusy_busy", 32'(busy0), 0);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        check("stale_busy", 32'(busy0), 0);
        check("stale_vld", 32'(g0v), 0);

        // Done with a waiting request goes straight to a new grant.
        req0 = 32'h0000_0200;
        push0();
        expect_grant0("g9");
        fire0("f9");
        req0 = 32'h0000_0100;
        push0();
        done0 = 1'b1;
        expect_grant0("g8");
        done0 = 1'b0;
        check("g8_busy", 32'(busy0), 0);
        req0 = '0;
        #1 check("noreq_comb", 32'(noreq0), 1);

        // Pipelined unit: one grant per cycle sweeping every index.
        req1 = 32'hFFFF_FFFF;
        ready1 = 1'b1;
        p = 0;
        prev = -1;
        for (int i = 0; i < 33; i++) begin
            m = req1;
            if (prev >= 0) m[prev] = 1'b0;
            e = ref_pick(m, p);
            q1.push_back(e);
            prev = e;
            p = (e + 1) % 32;
        end
        for (int i = 0; i < 32; i++) seen[i] = 0;
        n = 0;
        k = 0;
        while (q1.size() > 0 && n < 40) begin
            step();
            n++;
            if (g1v) begin
                e = q1.pop_front();
                check("pipe_idx", 32'(g1idx), e);
                if (k < 32) seen[g1idx]++;
                k++;
            end
        end
        check("pipe_left", 32'(q1.size()), 0);
        check("pipe_cycles", n, 33);
        for (int i = 0; i < 32; i++) check("pipe_once", seen[i], 1);
        ready1 = 1'b0;
        req1 = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb32.md
Name: rr_arb32

Overview:
- 32-requester round-robin arbiter that shares one functional unit (for example a shared multi-cycle divider) among issue slots of the OOO core.
- Selects one requester at a time and holds a stable, registered grant until the unit accepts it.
- Optionally tracks the unit as busy until it signals done.
- Detects "no requests" by feeding the inverted request vector through the existing 32-input AND-reduction cell.

Parameters:
- NUM_REQ, 32, number of requesters; fixed at 32 to match the AND-reduction cell.
- IDX_W, 5, width of the grant index.
- PIPELINED_UNIT, 0. When 1, the unit accepts a new operation every cycle and the BUSY state is skipped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  32  level requests; a requester holds its bit until its grant fires
- flush  in  1  synchronous pipeline flush; cancels any pending grant
- unit_ready  in  1  unit accepts the presented grant this cycle
- unit_done  in  1  unit has finished the accepted operation; ignored unless in BUSY
- gnt_valid  out  1  a grant is presented
- gnt_onehot  out  32  one-hot grant, registered
- gnt_idx  out  5  binary index of the granted requester, registered
- busy  out  1  unit is occupied (state BUSY)
- no_req  out  1  combinational: every req bit is 0 (AND of ~req)

Behaviour:
- Reset, when rst=1 at a clk edge: state=IDLE, ptr=0, gnt_valid=0, gnt_onehot=0, gnt_idx=0, busy=0. Reset mid-grant or mid-BUSY drops everything with no completion.
- Selection:
  - The winner is the first set bit of req scanning ptr, ptr+1, … mod 32.
  - The scan wraps from bit 31 to bit 0.
- Handshake: fire = gnt_valid & unit_ready.
- States:
  - IDLE: if no_req=0, register the winner and go to GRANT. Latency: a req first seen at edge t gives gnt_valid=1 from t+1.
  - GRANT: gnt_valid=1, and gnt_onehot/gnt_idx stay stable until fire. On fire, set ptr = gnt_idx+1 mod 32 (31 wraps to 0).
    - PIPELINED_UNIT=0: go to BUSY.
    - PIPELINED_UNIT=1: if any other req is pending, re-arbitrate on the same edge using the updated ptr and stay in GRANT (back-to-back grants, one per cycle). Otherwise go to IDLE.
  - BUSY: busy=1, gnt_valid=0, gnt_onehot=0.
    - unit_done with no_req=0: go directly to GRANT with a fresh selection (no idle bubble).
    - unit_done with no_req=1: go to IDLE.
- Requester rule: the granted requester drops req on the cycle after fire. The arbiter masks the granted bit during the fire edge so it cannot be re-selected that edge.
- flush:
  - Highest priority after rst.
  - From GRANT with no fire: go to IDLE, ptr unchanged.
  - From GRANT with fire on the same cycle: flush wins, the fire is discarded and ptr is unchanged. The unit must also observe flush.
  - From BUSY: go to IDLE, and unit_done is ignored thereafter.
- Fairness: every continuously asserted requester is granted within 32 fires.
- Invariants:
  - gnt_onehot has at most one bit set.
  - gnt_onehot equals the decode of gnt_idx whenever gnt_valid=1.
  - gnt_onehot=0 whenever gnt_valid=0.

Decomposition:
- Shared package:
  - NUM_REQ and IDX_W constants.
  - State encoding IDLE=2'd0, GRANT=2'd1, BUSY=2'd2.
  - A onehot-to-index function, reused by other selectors.
- Sub-modules:
  - and32: instantiate it for no_req.
  - rr_pick32, the natural separate unit: combinational rotate, priority-find, rotate-back. Its inputs are req and ptr; its outputs are the one-hot winner and index.

Test Plan:
- Reset then req=32'h0000_0001 → gnt_valid=1 one cycle later, gnt_idx=0, gnt_onehot=1. unit_ready=1 → busy=1, ptr=1. unit_done → IDLE, busy=0.
- req=32'hFFFF_FFFF held, PIPELINED_UNIT=1, unit_ready=1 always → gnt_idx sequence 0,1,2,…,31,0, one grant per cycle. Each index appears exactly once per 32 cycles.
- ptr=31 with req bits 31 and 0 set → grant 31; after fire → grant 0 (wrap), ptr=1.
- In GRANT with unit_ready=0 for 5 cycles while other req bits toggle → gnt_onehot/gnt_idx unchanged all 5 cycles. Fire on cycle 6 → move to BUSY.
- Flush asserted on the same cycle as fire → state IDLE, ptr unchanged, busy=0. Flush during BUSY followed by a unit_done pulse → no state change.
- In BUSY, unit_done together with req=32'h0000_0100 → next cycle state GRANT with gnt_idx=8 and no IDLE cycle. req=0 → no_req=1 combinationally.
